// File: rtl/draw_paddle_pipe.sv
// Paddle overlay stage for the PONG video chain: paints one rectangle of `color`
// over the pixel stream. All timing signals are delayed by PIPE_STAGES to match rgb.
module draw_paddle_pipe #(
  parameter int X_LEFT       = 50,
  parameter int WIDTH        = 10,
  parameter int LENGTH       = 80,
  parameter int V_RES        = 600,
  parameter int PIPE_STAGES  = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] y_pos,
  input  logic [11:0] color,
  input  logic        outline_en,
  input  logic        blink_en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0]   X_LO     = 12'(X_LEFT);
  localparam logic [11:0]   X_HI     = 12'(X_LEFT + WIDTH - 1);
  localparam logic [11:0]   Y_MAX    = 12'(V_RES - LENGTH);
  localparam logic [11:0]   LEN      = 12'(LENGTH);
  localparam logic [11:0]   LEN_M1   = 12'(LENGTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } pix_t;

  logic          vblnk_q;
  logic [11:0]   y_lat_q, y_lat_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          visible_q, visible_d;
  logic          fe;

  assign fe = vblnk_in & ~vblnk_q;

  // y is sampled only at the start of vertical blank so the paddle never tears
  always_comb begin
    y_lat_d     = y_lat_q;
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    if (fe) begin
      y_lat_d = (y_pos > Y_MAX) ? Y_MAX : y_pos;
    end
    if (!blink_en) begin
      frame_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (fe) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      y_lat_q     <= '0;
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      vblnk_q     <= vblnk_in;
      y_lat_q     <= y_lat_d;
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
    end
  end

  logic [11:0] hc, vc, y_end, y_last;
  logic        in_x, in_y, border, paint;
  pix_t        stage_d;

  assign hc     = {1'b0, hcount_in};
  assign vc     = {1'b0, vcount_in};
  assign y_end  = y_lat_q + LEN;
  assign y_last = y_lat_q + LEN_M1;
  assign in_x   = (hc >= X_LO) && (hc <= X_HI);
  assign in_y   = (vc >= y_lat_q) && (vc < y_end);
  assign border = (hc == X_LO) || (hc == X_HI) || (vc == y_lat_q) || (vc == y_last);
  assign paint  = in_x & in_y & visible_q & (~outline_en | border) & ~hblnk_in & ~vblnk_in;

  always_comb begin
    stage_d.hcount = hcount_in;
    stage_d.vcount = vcount_in;
    stage_d.hsync  = hsync_in;
    stage_d.vsync  = vsync_in;
    stage_d.hblnk  = hblnk_in;
    stage_d.vblnk  = vblnk_in;
    stage_d.rgb    = paint ? color : rgb_in;
  end

  // Stage 0 captures the composited pixel; later stages are plain delay
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      pix_t pipe_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge pclk) begin
          if (rst) pipe_q <= '0;
          else     pipe_q <= stage_d;
        end
      end else begin : g_delay
        always_ff @(posedge pclk) begin
          if (rst) pipe_q <= '0;
          else     pipe_q <= g_stage[gi-1].pipe_q;
        end
      end
    end
  endgenerate

  pix_t out_q;
  assign out_q      = g_stage[PIPE_STAGES-1].pipe_q;
  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule
